// File: rtl/lcd_status_writer_pkg.sv
// Shared constants, types and character lookup for lcd_status_writer.
// Holds the ASCII codes, the text templates, the row-1 field positions,
// the FSM state encoding and the screen_char() helper that maps a
// (row, column) pair to the character to print.
package lcd_status_writer_pkg;

  localparam int unsigned VALUE_W    = 20;
  localparam int unsigned DIGITS     = 6;
  localparam int unsigned BCD_W      = 4 * DIGITS;
  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned POS_W      = 4;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned ITER_W     = 5;
  localparam int unsigned CONV_ITERS = VALUE_W;

  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] ASCII_DOT   = 8'h2E;
  localparam logic [CHAR_W-1:0] ASCII_ZERO  = 8'h30;

  // Column 15 of row 0 is replaced by the update counter.
  localparam logic [16*CHAR_W-1:0] ROW0_TEXT = "glip loopback   ";
  localparam logic [6*CHAR_W-1:0]  ROW1_TAIL = " Mb/s ";

  localparam logic [POS_W-1:0] POS_D5   = 4'd3;
  localparam logic [POS_W-1:0] POS_D4   = 4'd4;
  localparam logic [POS_W-1:0] POS_D3   = 4'd5;
  localparam logic [POS_W-1:0] POS_DOT  = 4'd6;
  localparam logic [POS_W-1:0] POS_D2   = 4'd7;
  localparam logic [POS_W-1:0] POS_D1   = 4'd8;
  localparam logic [POS_W-1:0] POS_D0   = 4'd9;
  localparam logic [POS_W-1:0] POS_TAIL = 4'd10;
  localparam logic [POS_W-1:0] POS_CNT  = 4'd15;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CONV  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // One character write toward the LCD driver buffer.
  typedef struct packed {
    logic [CHAR_W-1:0] data;
    logic [POS_W-1:0]  pos;
    logic              row;
  } lcd_write_t;

  localparam lcd_write_t WRITE_IDLE = '{data: ASCII_SPACE, pos: '0, row: 1'b0};

  function automatic logic [CHAR_W-1:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + CHAR_W'(d);
  endfunction

  // Character shown at (row, pos) for a given counter and BCD value.
  function automatic logic [CHAR_W-1:0] screen_char(input logic             row,
                                                    input logic [POS_W-1:0] pos,
                                                    input logic [CNT_W-1:0] upd,
                                                    input logic [BCD_W-1:0] bcd);
    logic [CHAR_W-1:0] c;
    logic [3:0] d5, d4, d3, d2, d1, d0;
    {d5, d4, d3, d2, d1, d0} = bcd;
    c = ASCII_SPACE;
    if (!row) begin
      if (pos == POS_CNT) c = digit_char(upd);
      else                c = CHAR_W'(ROW0_TEXT >> (8 * (15 - 32'(pos))));
    end else if (pos >= POS_TAIL) begin
      c = CHAR_W'(ROW1_TAIL >> (8 * (15 - 32'(pos))));
    end else begin
      case (pos)
        POS_D5:  c = (d5 == 4'd0) ? ASCII_SPACE : digit_char(d5);
        POS_D4:  c = (d5 == 4'd0 && d4 == 4'd0) ? ASCII_SPACE : digit_char(d4);
        POS_D3:  c = digit_char(d3);
        POS_DOT: c = ASCII_DOT;
        POS_D2:  c = digit_char(d2);
        POS_D1:  c = digit_char(d1);
        POS_D0:  c = digit_char(d0);
        default: c = ASCII_SPACE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/lcd_status_writer_if.sv
// Update handshake and LCD character write port of lcd_status_writer.
//   in_value/in_valid/in_ready : throughput update handshake
//   out_data/out_enable/out_pos/out_row : character write to LCD driver
// master = the side feeding updates and observing writes; slave = the block.
interface lcd_status_writer_if;
  import lcd_status_writer_pkg::*;

  logic [VALUE_W-1:0] in_value;
  logic               in_valid;
  logic               in_ready;
  logic [CHAR_W-1:0]  out_data;
  logic               out_enable;
  logic [POS_W-1:0]   out_pos;
  logic               out_row;

  modport master (
    output in_value, in_valid,
    input  in_ready, out_data, out_enable, out_pos, out_row
  );

  modport slave (
    input  in_value, in_valid,
    output in_ready, out_data, out_enable, out_pos, out_row
  );
endinterface

// File: rtl/lcd_status_writer_bin2bcd_seq.sv
// Sequential 20-bit binary to 6-digit BCD converter (double-dabble).
// Ports: clk, rst (sync, active-high), start (load bin_in),
//        bin_in (20-bit binary), done (one-cycle pulse), bcd_out (24-bit BCD).
// The first shift happens on the start edge, so done is seen 20 cycles
// after the start cycle and bcd_out then holds the result.
module bin2bcd_seq
  import lcd_status_writer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VALUE_W-1:0] bin_in,
  output logic               done,
  output logic [BCD_W-1:0]   bcd_out
);

  logic [VALUE_W-1:0] bin_q;
  logic [ITER_W-1:0]  iter_q;
  logic               busy_q;
  logic [BCD_W-1:0]   corr_c;

  // Add 3 to every nibble that is 5 or more, ahead of the next shift.
  always_comb begin
    corr_c = bcd_out;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_out[4*i +: 4] >= 4'd5) corr_c[4*i +: 4] = bcd_out[4*i +: 4] + 4'd3;
    end
  end

  // Shift register {bcd, bin}, one corrected shift per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      bcd_out <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {bcd_out, bin_q} <= {(BCD_W - 1)'(0), bin_in, 1'b0};
        iter_q           <= ITER_W'(1);
        busy_q           <= 1'b1;
      end else if (busy_q) begin
        {bcd_out, bin_q} <= {corr_c[BCD_W-2:0], bin_q, 1'b0};
        iter_q           <= iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(CONV_ITERS - 1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_status_writer.sv
// Formats a kbit/s throughput value as "ddd.ddd Mb/s" on a 2x16 LCD buffer.
// Ports: clk, rst (sync, active-high),
//        bus (slave): in_value/in_valid/in_ready update handshake and
//        out_data/out_enable/out_pos/out_row character write port.
// Each accepted update is converted to BCD, then all 32 characters are
// rewritten one per cycle. Output registers are loaded from the next
// state so writes line up with the WRITE state cycle by cycle.
module lcd_status_writer
  import lcd_status_writer_pkg::*;
#(
  parameter int unsigned MAX_VALUE = 999999
) (
  input logic clk,
  input logic rst,
  lcd_status_writer_if.slave bus
);

  localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VALUE);

  state_t             state, next_state;
  logic [IDX_W-1:0]   widx, widx_next;
  logic [CNT_W-1:0]   upd_cnt;
  logic               accept_c;
  logic [VALUE_W-1:0] sat_value_c;
  logic               conv_done;
  logic [BCD_W-1:0]   bcd;

  logic               ready_q, ready_d;
  logic               en_q, en_d;
  lcd_write_t         wr_q, wr_d;

  assign accept_c    = ready_q && bus.in_valid;
  assign sat_value_c = (bus.in_value > MAX_V) ? MAX_V : bus.in_value;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_c),
    .bin_in  (sat_value_c),
    .done    (conv_done),
    .bcd_out (bcd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= next_state;
  end

  // Next-state and write-index logic.
  always_comb begin
    next_state = state;
    widx_next  = widx;
    case (state)
      ST_INIT: begin
        next_state = ST_WRITE;
        widx_next  = '0;
      end
      ST_IDLE: begin
        if (accept_c) next_state = ST_CONV;
      end
      ST_CONV: begin
        if (conv_done) begin
          next_state = ST_WRITE;
          widx_next  = '0;
        end
      end
      ST_WRITE: begin
        if (widx == IDX_W'(31)) next_state = ST_IDLE;
        else                    widx_next  = widx + IDX_W'(1);
      end
      default: next_state = ST_INIT;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    ready_d = (next_state == ST_IDLE);
    en_d    = 1'b0;
    wr_d    = WRITE_IDLE;
    if (next_state == ST_WRITE) begin
      en_d      = 1'b1;
      wr_d.pos  = widx_next[POS_W-1:0];
      wr_d.row  = widx_next[IDX_W-1];
      wr_d.data = screen_char(widx_next[IDX_W-1], widx_next[POS_W-1:0], upd_cnt, bcd);
    end
  end

  // Output registers, write index and update counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      wr_q    <= WRITE_IDLE;
      widx    <= '0;
      upd_cnt <= '0;
    end else begin
      ready_q <= ready_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      widx    <= widx_next;
      if (accept_c) upd_cnt <= (upd_cnt == CNT_W'(9)) ? '0 : upd_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.out_enable = en_q;
  assign bus.out_data   = wr_q.data;
  assign bus.out_pos    = wr_q.pos;
  assign bus.out_row    = wr_q.row;

endmodule

// File: tb/tb_lcd_status_writer.sv
// Self-checking bench for lcd_status_writer: table of directed updates,
// hand-written hold/reset sequences and random updates against a
// string-formatting reference of the screen contents.
module tb_lcd_status_writer;

  localparam int unsigned MAXV = 999999;

  typedef struct packed {
    logic [19:0]  value;
    logic [127:0] row1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   model_cnt = 0;

  lcd_status_writer_if bus ();

  lcd_status_writer #(.MAX_VALUE(MAXV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic void check(input bit ok, input string name, input string got, input string want);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s: got %s, required %s", name, got, want);
    end
  endfunction

  function automatic logic [127:0] str16(input string s);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[8*(15-i) +: 8] = s[i];
    return r;
  endfunction

  // Reference screen: integer Mb/s part right-justified in 3 columns.
  function automatic logic [127:0] model_row1(input int unsigned v);
    int unsigned s = (v > MAXV) ? MAXV : v;
    return str16($sformatf("   %3d.%03d Mb/s ", s / 1000, s % 1000));
  endfunction

  function automatic logic [127:0] model_row0(input int c);
    return str16($sformatf("glip loopback  %0d", c));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the 32-write burst and checks timing, order and text.
  task automatic expect_screen(input string tag, input logic [127:0] r0, input logic [127:0] r1,
                               input int first, output int last);
    bit seen = 1'b0;
    logic [7:0] exp_ch;
    bit ok;
    int start;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_enable;
    end
    check(seen, {tag, "_start"}, "no write", "a write burst");
    if (!seen) begin
      last = cyc;
      return;
    end
    start = cyc;
    check(start == first, {tag, "_first_cycle"}, $sformatf("%0d", start), $sformatf("%0d", first));
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      exp_ch = (k < 16) ? 8'(r0 >> (8 * (15 - k))) : 8'(r1 >> (8 * (31 - k)));
      ok = bus.out_enable && bus.out_pos == 4'(k % 16) && bus.out_row == 1'(k / 16) &&
           bus.out_data == exp_ch && !bus.in_ready;
      check(ok, $sformatf("%s_write%0d", tag, k),
            $sformatf("en=%0b pos=%0d row=%0b data=%02h ready=%0b", bus.out_enable, bus.out_pos,
                      bus.out_row, bus.out_data, bus.in_ready),
            $sformatf("en=1 pos=%0d row=%0d data=%02h ready=0", k % 16, k / 16, exp_ch));
    end
    @(negedge clk);
    check(!bus.out_enable && bus.in_ready, {tag, "_ready_after"},
          $sformatf("en=%0b ready=%0b", bus.out_enable, bus.in_ready), "en=0 ready=1");
    last = cyc;
  endtask

  // Waits (bounded) for the cycle in which the held update is accepted.
  task automatic wait_accept(output int t);
    bit got = 1'b0;
    t = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        t = cyc;
      end
    end
    check(got, "accept", "in_ready never high", "update accepted");
  endtask

  task automatic send(input logic [19:0] v, output int t);
    tick();
    bus.in_value = v;
    bus.in_valid = 1'b1;
    wait_accept(t);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic update(input string tag, input logic [19:0] v, input logic [127:0] row1);
    int t, last;
    send(v, t);
    model_cnt = (model_cnt + 1) % 10;
    expect_screen(tag, model_row0(model_cnt), row1, t + 21, last);
  endtask

  vec_t vecs[9];

  initial begin
    int r, t, t1, last, last2;
    logic [19:0] va, vb, rv;

    vecs[0] = '{20'd123456,  "   123.456 Mb/s "};
    vecs[1] = '{20'd1048575, "   999.999 Mb/s "};
    vecs[2] = '{20'd7,       "     0.007 Mb/s "};
    vecs[3] = '{20'd45000,   "    45.000 Mb/s "};
    vecs[4] = '{20'd999999,  "   999.999 Mb/s "};
    vecs[5] = '{20'd1000000, "   999.999 Mb/s "};
    vecs[6] = '{20'd0,       "     0.000 Mb/s "};
    vecs[7] = '{20'd1000,    "     1.000 Mb/s "};
    vecs[8] = '{20'd100000,  "   100.000 Mb/s "};

    bus.in_value = '0;
    bus.in_valid = 1'b0;

    // Reset state while rst is held.
    repeat (3) tick();
    @(negedge clk);
    check(!bus.out_enable && !bus.in_ready && bus.out_data == 8'h20 && bus.out_pos == 4'd0 &&
          !bus.out_row, "reset_state",
          $sformatf("en=%0b ready=%0b data=%02h pos=%0d row=%0b", bus.out_enable, bus.in_ready,
                    bus.out_data, bus.out_pos, bus.out_row),
          "en=0 ready=0 data=20 pos=0 row=0");
    tick();
    rst = 1'b0;
    r = cyc;
    expect_screen("init", str16("glip loopback  0"), str16("     0.000 Mb/s "), r + 1, last);

    // Directed table.
    for (int i = 0; i < 9; i++) update($sformatf("vec%0d", i), vecs[i].value, vecs[i].row1);

    // in_valid held through a write burst: second update waits for in_ready.
    va = 20'd54321;
    vb = 20'd2500;
    tick();
    bus.in_value = va;
    bus.in_valid = 1'b1;
    wait_accept(t1);
    tick();
    bus.in_value = vb;
    model_cnt = (model_cnt + 1) % 10;
    expect_screen("hold_a", model_row0(model_cnt), model_row1(va), t1 + 21, last);
    tick();
    bus.in_valid = 1'b0;
    model_cnt = (model_cnt + 1) % 10;
    expect_screen("hold_b", model_row0(model_cnt), model_row1(vb), last + 21, last2);

    // Random updates with random idle gaps.
    for (int i = 0; i < 14; i++) begin
      rv = 20'($urandom_range(0, 20'hFFFFF));
      if (i % 4 == 0) rv = 20'($urandom_range(0, 1999));
      update($sformatf("rand%0d", i), rv, model_row1(rv));
      repeat ($urandom_range(0, 3)) begin
        tick();
        @(negedge clk);
        check(!bus.out_enable && bus.in_ready, "idle_gap",
              $sformatf("en=%0b ready=%0b", bus.out_enable, bus.in_ready), "en=0 ready=1");
      end
    end

    // Reset asserted in cycle T+30 of an update.
    send(20'd777777, t);
    repeat (29) tick();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check(!bus.out_enable && !bus.in_ready && bus.out_data == 8'h20 && bus.out_pos == 4'd0 &&
          !bus.out_row, "midreset_state",
          $sformatf("en=%0b ready=%0b data=%02h pos=%0d row=%0b", bus.out_enable, bus.in_ready,
                    bus.out_data, bus.out_pos, bus.out_row),
          "en=0 ready=0 data=20 pos=0 row=0");
    tick();
    rst = 1'b0;
    r = cyc;
    model_cnt = 0;
    expect_screen("reinit", model_row0(0), model_row1(0), r + 1, last);
    update("post_reset", 20'd314159, model_row1(314159));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lcd_status_writer.md
# lcd_status_writer

Formats a throughput value into the two-row, 16-character text buffer of the character-LCD driver in the loopback demo. It sits directly upstream of the LCD driver and drives that driver's character write port (`in_data`/`in_enable`/`in_pos`/`in_row`). Each accepted update is converted from binary to decimal with a sequential double-dabble, then all 32 characters are rewritten, one per cycle.

## Interface
- `MAX_VALUE`, default 999999: saturation limit for `in_value`, in kbit/s.
- `clk` input, 1 bit: the single clock, also clocking the LCD driver's buffer.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_value` input, 20 bits: throughput in kbit/s.
- `in_valid` input, 1 bit: `in_value` is valid.
- `in_ready` output, 1 bit: block is idle and accepts an update.
- `out_data` output, 8 bits: ASCII character, goes to the driver's `in_data`.
- `out_enable` output, 1 bit: write strobe, goes to `in_enable`.
- `out_pos` output, 4 bits: column 0..15, goes to `in_pos`.
- `out_row` output, 1 bit: 0 is the top row, 1 is the bottom row; goes to `in_row`.

## Operation
- **States:** INIT, IDLE, CONV, WRITE.
- **Reset** (while `rst` is high and in the cycle after):
  - `in_ready`=0, `out_enable`=0, `out_data`=0x20, `out_pos`=0, `out_row`=0.
  - Update counter cleared to 0; digit registers cleared to 0.
  - State goes to INIT.
- **INIT:** goes straight to WRITE with all digits 0, giving a defined screen after power-up.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid & in_ready`, capture min(`in_value`, `MAX_VALUE`), increment the update counter (wraps 9 to 0), go to CONV.
- **CONV:**
  - Double-dabble, 20 shift iterations, one per cycle, producing 6 BCD digits d5..d0.
  - Then go to WRITE.
- **WRITE:**
  - 32 consecutive cycles with `out_enable`=1.
  - Row 0 positions 0..15 first, then row 1 positions 0..15. No gaps; the driver has no backpressure.
  - Then return to IDLE.
- **Row 0 text:** "glip loopback  N".
  - Position 15 is N = '0' + update counter (0x30..0x39).
- **Row 1 layout:**
  - Positions 0-2: spaces.
  - Positions 3-5: d5 d4 d3.
  - Position 6: '.'.
  - Positions 7-9: d2 d1 d0.
  - Positions 10-15: " Mb/s ".
- **Leading-zero suppression:**
  - d5 becomes a space if 0.
  - d4 becomes a space if d5 and d4 are both 0.
  - d3 and the fraction digits are always printed.
- **Arithmetic:**
  - Saturation compare is done on the full 20 bits.
  - BCD add-3 correction is applied when a nibble is ≥5, before each shift.
  - Digits map to ASCII as 0x30 + digit.
- **Handshake:**
  - `in_ready`=0 in INIT, CONV and WRITE.
  - `in_valid` is ignored while `in_ready`=0; the source must hold its value until accepted.
  - If `in_valid` and `in_ready` are both high in the same cycle, the update is accepted in that cycle.
- **Reset mid-operation:** CONV or WRITE is aborted and `out_enable` is 0 in the next cycle. A fresh INIT pass then rewrites the full screen with value 0 and counter '0'.

## Timing
- All outputs are registered.
- **After reset release** (R = first cycle with `rst` low):
  - Writes occur in cycles R+1..R+32.
  - `in_ready`=1 from R+33.
- **After an accepted update** (accepted in cycle T):
  - CONV occupies T+1..T+20.
  - Writes occur in T+21..T+52: row 0 in T+21..T+36, row 1 in T+37..T+52.
  - `in_ready`=1 from T+53.
- **Throughput:** at most one update per 53 cycles.
- **Position and row:** `out_pos` increments by 1 each write cycle and wraps 15 to 0. `out_row` toggles to 1 on that wrap.
- **No-write cycles:** `out_enable` is 0 in every cycle outside WRITE.

## Structure
- **Shared constants (include file `lcd_status_defs.vh`):**
  - ASCII codes for space, '.', '0', and the characters of "glip loopback" and " Mb/s ".
  - Row-1 field positions.
  - State encodings.
- **Sub-module `bin2bcd_seq`:**
  - Ports: start, 20-bit binary in, done pulse, 24-bit BCD out.
  - 20-cycle iterative double-dabble.
- **Top level:** FSM, update counter and character multiplexer.

## Test plan
- Reset, then release -> 32 writes starting at R+1; row 0 is "glip loopback  0", row 1 is "     0.000 Mb/s "; `in_ready` rises at R+33.
- Update 123456 accepted at T -> row 1 is "   123.456 Mb/s ", row 0 position 15 is '1'; first write at T+21, last at T+52.
- Update 1048575 -> saturates, row 1 is "   999.999 Mb/s "; update 7 -> "     0.007 Mb/s "; update 45000 -> "    45.000 Mb/s ".
- Eleven consecutive updates -> row 0 position 15 shows '1'..'9', '0', '1'; `in_valid` held high during WRITE is accepted only in the first cycle with `in_ready`=1.
- Assert `rst` at T+30 mid-update -> `out_enable`=0 next cycle, then a full INIT pass rewrites the value-0 screen with counter '0'.
